// File: rtl/line_follow_ctrl.sv
// Line-follower steering controller: synchronises and debounces the IR
// sensor array, classifies line position by left/right weight, and runs a
// follow/node/search/lost state machine with node counting and a timeout.
module line_follow_ctrl #(
    parameter int NUM_SENSORS  = 3,
    parameter int FILT_DEPTH   = 4,
    parameter int NODE_HOLD    = 25000,
    parameter int LOST_TIMEOUT = 50000,
    parameter int NODE_CNT_W   = 8
) (
    input  logic                   clk_50,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_SENSORS-1:0] sensor,
    output logic [2:0]             turn,
    output logic                   node_pulse,
    output logic [NODE_CNT_W-1:0]  node_count,
    output logic                   lost,
    output logic [2:0]             state_dbg
);

    localparam int C       = (NUM_SENSORS - 1) / 2;
    localparam int CNT_W   = $clog2(NUM_SENSORS + 1);
    localparam int RUN_W   = $clog2(FILT_DEPTH + 1);
    localparam int TMR_MAX = (NODE_HOLD > LOST_TIMEOUT) ? NODE_HOLD : LOST_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(FILT_DEPTH - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(NODE_HOLD - 1);
    localparam logic [TMR_W-1:0] LOST_LAST = TMR_W'(LOST_TIMEOUT - 1);

    localparam logic [2:0] TURN_STOP   = 3'b000;
    localparam logic [2:0] TURN_FWD    = 3'b001;
    localparam logic [2:0] TURN_LEFT   = 3'b010;
    localparam logic [2:0] TURN_RIGHT  = 3'b011;
    localparam logic [2:0] TURN_SEARCH = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_FOLLOW = 3'b001,
        ST_NODE   = 3'b010,
        ST_SEARCH = 3'b011,
        ST_LOST   = 3'b100
    } state_t;

    typedef enum logic [2:0] {
        CL_NONE,
        CL_NODE,
        CL_FWD,
        CL_LEFT,
        CL_RIGHT
    } class_t;

    typedef enum logic [1:0] {
        DIR_FWD,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    logic [NUM_SENSORS-1:0] r_sync1;
    logic [NUM_SENSORS-1:0] r_sync2;
    logic [NUM_SENSORS-1:0] r_filt;
    logic [RUN_W-1:0]       r_run [NUM_SENSORS];

    logic [CNT_W-1:0] w_left_cnt;
    logic [CNT_W-1:0] w_right_cnt;
    class_t           w_class;
    logic [2:0]       w_dir_turn;
    logic             w_class_is_dir;
    dir_t             w_class_dir;
    logic [2:0]       w_search_turn;

    state_t                r_state;
    logic [2:0]            r_turn;
    logic                  r_pulse;
    logic [NODE_CNT_W-1:0] r_node_count;
    logic                  r_lost;
    logic [TMR_W-1:0]      r_timer;
    dir_t                  r_last_dir;

    state_t                w_next_state;
    logic [2:0]            w_next_turn;
    logic                  w_next_pulse;
    logic [NODE_CNT_W-1:0] w_next_count;
    logic [TMR_W-1:0]      w_next_timer;
    dir_t                  w_next_dir;

    // Two-flop synchroniser for the asynchronous sensor inputs
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sensor;
            r_sync2 <= r_sync1;
        end
    end

    // Per-bit debounce: flip the filtered bit after FILT_DEPTH disagreeing samples in a row
    // NOTE: the run-counter array is a handful of flops, so it is reset like any other register.
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_filt <= '0;
            for (int i = 0; i < NUM_SENSORS; i++) r_run[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_run[i] <= '0;
                end else if (r_run[i] == RUN_LAST) begin
                    r_filt[i] <= r_sync2[i];
                    r_run[i]  <= '0;
                end else begin
                    r_run[i] <= r_run[i] + 1'b1;
                end
            end
        end
    end

    // Classify line position from the filtered pattern (left/right weight)
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_left_cnt  = '0;
        w_right_cnt = '0;
        for (int i = 0; i < C; i++)
            w_left_cnt = w_left_cnt + CNT_W'(r_filt[i]);
        for (int i = C + 1; i < NUM_SENSORS; i++)
            w_right_cnt = w_right_cnt + CNT_W'(r_filt[i]);

        if (&r_filt)                     w_class = CL_NODE;
        else if (~|r_filt)               w_class = CL_NONE;
        else if (w_left_cnt > w_right_cnt) w_class = CL_LEFT;
        else if (w_right_cnt > w_left_cnt) w_class = CL_RIGHT;
        else                             w_class = CL_FWD;

        w_dir_turn     = TURN_STOP;
        w_class_is_dir = 1'b1;
        w_class_dir    = DIR_FWD;
        case (w_class)
            CL_FWD:   w_dir_turn = TURN_FWD;
            CL_LEFT:  begin w_dir_turn = TURN_LEFT;  w_class_dir = DIR_LEFT;  end
            CL_RIGHT: begin w_dir_turn = TURN_RIGHT; w_class_dir = DIR_RIGHT; end
            default:  w_class_is_dir = 1'b0;
        endcase

        case (r_last_dir)
            DIR_LEFT:  w_search_turn = TURN_LEFT;
            DIR_RIGHT: w_search_turn = TURN_RIGHT;
            default:   w_search_turn = TURN_SEARCH;
        endcase
    end

    // FSM next state and next registered outputs; enable low overrides everything
    always_comb begin
        w_next_state = r_state;
        w_next_turn  = r_turn;
        w_next_pulse = 1'b0;
        w_next_count = r_node_count;
        w_next_timer = r_timer;
        w_next_dir   = r_last_dir;

        if (!enable) begin
            w_next_state = ST_IDLE;
            w_next_turn  = TURN_STOP;
            w_next_timer = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_next_state = ST_FOLLOW;
                    w_next_turn  = w_dir_turn;
                    if (w_class_is_dir) w_next_dir = w_class_dir;
                end
                ST_FOLLOW: begin
                    case (w_class)
                        CL_NODE: begin
                            w_next_state = ST_NODE;
                            w_next_turn  = TURN_STOP;
                            w_next_pulse = 1'b1;
                            w_next_count = r_node_count + 1'b1;
                            w_next_timer = '0;
                        end
                        CL_NONE: begin
                            w_next_state = ST_SEARCH;
                            w_next_turn  = w_search_turn;
                            w_next_timer = '0;
                        end
                        default: begin
                            w_next_turn = w_dir_turn;
                            w_next_dir  = w_class_dir;
                        end
                    endcase
                end
                ST_NODE: begin
                    // Hold completes before the line is looked at again
                    if (r_timer != HOLD_LAST) begin
                        w_next_timer = r_timer + 1'b1;
                        w_next_turn  = TURN_STOP;
                    end else if (w_class == CL_NODE) begin
                        w_next_turn = TURN_FWD;
                    end else begin
                        w_next_state = ST_FOLLOW;
                        w_next_turn  = w_dir_turn;
                        if (w_class_is_dir) w_next_dir = w_class_dir;
                    end
                end
                ST_SEARCH: begin
                    // A reappearing line beats a timer expiring on the same edge
                    if (w_class != CL_NONE) begin
                        w_next_state = ST_FOLLOW;
                        w_next_turn  = w_dir_turn;
                        if (w_class_is_dir) w_next_dir = w_class_dir;
                    end else if (r_timer == LOST_LAST) begin
                        w_next_state = ST_LOST;
                        w_next_turn  = TURN_STOP;
                    end else begin
                        w_next_timer = r_timer + 1'b1;
                        w_next_turn  = w_search_turn;
                    end
                end
                ST_LOST: begin
                    w_next_turn = TURN_STOP;
                end
                default: begin
                    w_next_state = ST_IDLE;
                    w_next_turn  = TURN_STOP;
                end
            endcase
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_turn       <= TURN_STOP;
            r_pulse      <= 1'b0;
            r_node_count <= '0;
            r_lost       <= 1'b0;
            r_timer      <= '0;
            r_last_dir   <= DIR_FWD;
        end else begin
            r_state      <= w_next_state;
            r_turn       <= w_next_turn;
            r_pulse      <= w_next_pulse;
            r_node_count <= w_next_count;
            r_lost       <= (w_next_state == ST_LOST);
            r_timer      <= w_next_timer;
            r_last_dir   <= w_next_dir;
        end
    end

    assign turn       = r_turn;
    assign node_pulse = r_pulse;
    assign node_count = r_node_count;
    assign lost       = r_lost;
    assign state_dbg  = r_state;

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Directed bench for line_follow_ctrl: a 3-sensor and a 5-sensor instance
// share clock, reset and enable; expected values are hand-derived.
module tb_line_follow_ctrl;

    localparam int HOLD = 20;
    localparam int TMO  = 100;

    logic       clk_50 = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] sensor3;
    logic [4:0] sensor5;

    logic [2:0] turn3, state3, turn5, state5;
    logic       pulse3, lost3, pulse5, lost5;
    logic [7:0] count3, count5;

    int total = 0;
    int bad   = 0;
    int extra_pulses;
    int stop_cycles;

    always #5 clk_50 = ~clk_50;

    line_follow_ctrl #(
        .NUM_SENSORS(3), .FILT_DEPTH(4), .NODE_HOLD(HOLD), .LOST_TIMEOUT(TMO), .NODE_CNT_W(8)
    ) dut3 (
        .clk_50(clk_50), .reset(reset), .enable(enable), .sensor(sensor3),
        .turn(turn3), .node_pulse(pulse3), .node_count(count3), .lost(lost3), .state_dbg(state3)
    );

    line_follow_ctrl #(
        .NUM_SENSORS(5), .FILT_DEPTH(4), .NODE_HOLD(HOLD), .LOST_TIMEOUT(TMO), .NODE_CNT_W(8)
    ) dut5 (
        .clk_50(clk_50), .reset(reset), .enable(enable), .sensor(sensor5),
        .turn(turn5), .node_pulse(pulse5), .node_count(count5), .lost(lost5), .state_dbg(state5)
    );

    // Patterns are written index-0-first (leftmost sensor first)
    function automatic logic [2:0] s3(input logic [2:0] p);
        logic [2:0] r;
        for (int i = 0; i < 3; i++) r[i] = p[2-i];
        return r;
    endfunction

    function automatic logic [4:0] s5(input logic [4:0] p);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) r[i] = p[4-i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_50);
    endtask

    task automatic one_node();
        sensor3 = s3(3'b111);
        step(30);
        sensor3 = s3(3'b010);
        step(10);
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        sensor3 = '0;
        sensor5 = '0;
        step(2);
        check("rst_turn",  turn3,  3'b000);
        check("rst_pulse", pulse3, 1'b0);
        check("rst_count", count3, 8'd0);
        check("rst_lost",  lost3,  1'b0);
        check("rst_state", state3, 3'b000);

        // Release; with no line the bot follows, then searches straight ahead
        reset  = 1'b0;
        enable = 1'b1;
        step(1);
        check("idle_to_follow", state3, 3'b001);
        step(2);
        check("early_search_state", state3, 3'b011);
        check("early_search_turn",  turn3,  3'b100);

        // Latency: 010 reaches turn on the 7th edge, not the 6th
        sensor3 = s3(3'b010);
        step(6);
        check("lat_edge6_turn", turn3, 3'b100);
        step(1);
        check("lat_edge7_turn",  turn3,  3'b001);
        check("lat_edge7_state", state3, 3'b001);
        check("lat_count",       count3, 8'd0);
        check("lat_lost",        lost3,  1'b0);

        sensor3 = s3(3'b110);
        step(7);
        check("left_turn", turn3, 3'b010);
        sensor3 = s3(3'b011);
        step(7);
        check("right_turn", turn3, 3'b011);

        // Three-cycle dropout shorter than the filter depth
        sensor3 = s3(3'b000);
        step(3);
        sensor3 = s3(3'b011);
        step(10);
        check("glitch_turn",  turn3,  3'b011);
        check("glitch_state", state3, 3'b001);

        // Node entry: single pulse, stop for HOLD cycles, then forward
        sensor3 = s3(3'b111);
        step(7);
        check("node_pulse",     pulse3, 1'b1);
        check("node_count1",    count3, 8'd1);
        check("node_entry_turn", turn3, 3'b000);
        check("node_state",     state3, 3'b010);
        extra_pulses = 0;
        stop_cycles  = 0;
        for (int k = 1; k <= HOLD + 49; k++) begin
            step(1);
            if (pulse3) extra_pulses++;
            if (k < HOLD && turn3 == 3'b000) stop_cycles++;
            if (k == HOLD) check("node_hold_end_turn", turn3, 3'b001);
        end
        check("node_no_extra_pulse", extra_pulses, 0);
        check("node_stop_cycles",    stop_cycles,  HOLD - 1);
        check("node_persist_state",  state3, 3'b010);
        check("node_persist_count",  count3, 8'd1);

        sensor3 = s3(3'b010);
        step(7);
        check("node_exit_state", state3, 3'b001);
        check("node_exit_turn",  turn3,  3'b001);

        // 255 more nodes wrap the 8-bit counter to zero
        for (int i = 0; i < 255; i++) begin
            one_node();
            if (i == 253) check("count_255", count3, 8'hff);
        end
        check("count_wrap", count3, 8'd0);
        one_node();
        check("count_after_wrap", count3, 8'd1);

        // Search keeps turning the last way, recovers before timeout
        sensor3 = s3(3'b011);
        step(8);
        check("pre_search_turn", turn3, 3'b011);
        sensor3 = s3(3'b000);
        step(7);
        check("search_right_turn",  turn3,  3'b011);
        check("search_right_state", state3, 3'b011);
        sensor3 = s3(3'b010);
        step(7);
        check("search_recover_state", state3, 3'b001);
        check("search_recover_turn",  turn3,  3'b001);

        // Second loss of line runs the timer out (last direction forward)
        sensor3 = s3(3'b000);
        step(7);
        check("search_fwd_turn", turn3, 3'b100);
        step(TMO - 1);
        check("tmo_minus1_state", state3, 3'b011);
        check("tmo_minus1_lost",  lost3,  1'b0);
        step(1);
        check("lost_state", state3, 3'b100);
        check("lost_flag",  lost3,  1'b1);
        check("lost_turn",  turn3,  3'b000);

        enable = 1'b0;
        step(1);
        check("disable_state", state3, 3'b000);
        check("disable_lost",  lost3,  1'b0);
        check("disable_turn",  turn3,  3'b000);

        // Five-sensor weighting
        enable  = 1'b1;
        sensor5 = s5(5'b11000);
        step(8);
        check("n5_left", turn5, 3'b010);
        sensor5 = s5(5'b00011);
        step(8);
        check("n5_right", turn5, 3'b011);
        sensor5 = s5(5'b01010);
        step(8);
        check("n5_equal_fwd", turn5, 3'b001);

        // Asynchronous reset between edges while searching
        check("pre_reset_search", state3, 3'b011);
        #2 reset = 1'b1;
        #1;
        check("async_rst_turn",  turn3,  3'b000);
        check("async_rst_state", state3, 3'b000);
        check("async_rst_count", count3, 8'd0);
        check("async_rst_lost",  lost3,  1'b0);
        check("async_rst_pulse", pulse3, 1'b0);
        step(1);
        reset = 1'b0;
        step(1);
        check("post_rst_follow", state3, 3'b001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_follow_ctrl.md
Name: line_follow_ctrl

Overview:
- Parametrised line-follower steering controller for the bot's IR sensor array. Replaces the fixed 3-sensor per-clock decoder.
- Synchronises and debounces N sensors, then classifies the line position by left/right weight.
- Runs a follow/node/search/lost state machine with node counting and a lost-line timeout.
- Its turn code drives the motor PWM controller. Its node count feeds the path planner.

Parameters:
- NUM_SENSORS, 3, sensor count; must be odd and >= 3. Centre index C = (NUM_SENSORS-1)/2. Index 0 is leftmost.
- FILT_DEPTH, 4, consecutive equal synchronised samples needed before a filtered sensor bit changes (>= 1).
- NODE_HOLD, 25000, cycles of stop output on node entry (>= 1).
- LOST_TIMEOUT, 50000, cycles in SEARCH before declaring lost (>= 1).
- NODE_CNT_W, 8, width of the node counter.

Ports:
- clk_50  in  1  50 MHz system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run request; low forces IDLE.
- sensor  in  NUM_SENSORS  raw sensor inputs, 1 = line seen, asynchronous to clk_50.
- turn  out  3  000 stop, 001 forward, 010 left, 011 right, 100 search.
- node_pulse  out  1  one-cycle pulse on node entry.
- node_count  out  NODE_CNT_W  nodes seen since reset.
- lost  out  1  high while in LOST.
- state_dbg  out  3  current FSM state encoding.

Behaviour:
- Reset (async, active-high) clears synchronisers, filters, counters and FSM.
  - FSM goes to IDLE.
  - turn=000, node_pulse=0, node_count=0, lost=0, state_dbg=000.
  - Reset asserted mid-operation takes effect immediately. Nothing is retained.
- Input path:
  - 2-flop synchroniser per bit.
  - Per-bit filter: a run counter tracks consecutive synchronised samples differing from the filtered bit. The filtered bit f[i] takes the new value when the run reaches FILT_DEPTH.
  - Any agreeing sample clears that run counter.
- Classification (combinational on f):
  - all ones -> NODE.
  - all zeros -> NONE.
  - else L = popcount(f[C-1:0]) and R = popcount(f[N-1:C+1]).
  - L>R -> LEFT; R>L -> RIGHT; L==R -> FORWARD.
- FSM states (state_dbg): IDLE=000, FOLLOW=001, NODE=010, SEARCH=011, LOST=100. turn and all outputs are registered.
- enable low in any state -> IDLE on the next edge. This has priority over every other transition.
- IDLE:
  - turn=000.
  - enable high -> FOLLOW.
- FOLLOW:
  - turn follows classification: FORWARD 001, LEFT 010, RIGHT 011.
  - Records last_dir in {forward, left, right}.
  - NODE -> enter NODE: node_pulse=1 for exactly that edge, node_count+1 (wraps at 2^NODE_CNT_W to 0), hold timer cleared.
  - NONE -> enter SEARCH with search timer cleared.
- NODE:
  - turn=000 for NODE_HOLD cycles, then turn=001 until the classification is not NODE.
  - Then go to FOLLOW. No further pulses while the node persists.
  - If the classification leaves NODE during the hold, the hold still completes first.
- SEARCH:
  - turn=010 if last_dir=left, 011 if right, 100 if forward.
  - Any classification other than NONE -> FOLLOW on the next edge.
  - Timer reaching LOST_TIMEOUT -> LOST. If a line reappears on the same edge the timer expires, FOLLOW wins.
- LOST:
  - turn=000, lost=1.
  - Exits only via enable low (-> IDLE) or reset.
- Latency: an input change held stable reaches turn after FILT_DEPTH+3 rising edges. This is 7 at the default.
- Glitches shorter than FILT_DEPTH cycles never reach classification.

Test Plan:
- Reset, enable=1, N=3, sensor=010 held -> turn=001 exactly 7 edges after the change; node_count=0, lost=0.
- sensor=110 -> turn=010. Then 011 -> turn=011. Then a 3-cycle 000 glitch inside 011 -> turn stays 011 (FILT_DEPTH=4).
- sensor=111 for NODE_HOLD+50 cycles -> a single node_pulse, node_count=1. turn=000 for exactly NODE_HOLD cycles, then 001. Returning to 010 -> FOLLOW with turn=001. 256 nodes with W=8 -> node_count wraps to 0.
- Last turn 011, then sensor=000 -> turn=011 (SEARCH). Sensor=010 restored before timeout -> FOLLOW. A second 000 held LOST_TIMEOUT cycles (set to 100 in the bench) -> turn=000, lost=1, state_dbg=100. enable low -> IDLE, lost=0.
- N=5, sensor=11000 (index 0 leftmost) -> turn=010. 00011 -> turn=011. 01010 (L==R) -> turn=001.
- Assert reset asynchronously mid-SEARCH, between clock edges -> all outputs 0 immediately. After release with enable=1 -> FOLLOW on the first edge.
